// File: rtl/controlador_display_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// with a multiplexed common-anode 7-segment scan driver.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   dato_bin    binary word to convert, latched when a request is accepted
//   cargar      start request, sampled on the clk edge, ignored while busy
//   habilitado  display enable; 0 blanks every digit at the next scan update
//   ocupado     high while a conversion is in progress
//   listo       one-cycle pulse when bcd_out has just been updated
//   bcd_out     converted result, nibble i is decimal digit i (LSD at [3:0])
//   anodos      digit selects, active low, at most one bit low
//   segmentos   segment bits {g,f,e,d,c,b,a}, active low
module controlador_display_bcd #(
    parameter int unsigned TAM_REG_BIN  = 16,
    parameter int unsigned NUM_DIGITOS  = (TAM_REG_BIN + 4) / 4,
    parameter int unsigned DIV_REFRESCO = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TAM_REG_BIN-1:0]   dato_bin,
    input  logic                     cargar,
    input  logic                     habilitado,
    output logic                     ocupado,
    output logic                     listo,
    output logic [TAM_REG_BIN+3:0]   bcd_out,
    output logic [NUM_DIGITOS-1:0]   anodos,
    output logic [6:0]               segmentos
);

    localparam int unsigned TAM_BCD   = TAM_REG_BIN + 4;
    localparam int unsigned CNT_IT_W  = $clog2(TAM_REG_BIN + 1);
    localparam int unsigned CNT_REF_W = $clog2(DIV_REFRESCO);
    localparam int unsigned IDX_W     = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;

    typedef enum logic [1:0] {
        REPOSO       = 2'd0,
        CONVIRTIENDO = 2'd1,
        FIN          = 2'd2
    } estado_t;

    estado_t                estado;
    logic [TAM_REG_BIN-1:0] bin;
    logic [TAM_BCD-1:0]     acumulador;
    logic [TAM_BCD-1:0]     ajustado;
    logic [CNT_IT_W-1:0]    iter;

    logic [CNT_REF_W-1:0]   cnt_ref;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_sig;
    logic [3:0]             digito_sel;
    logic                   apagado_sel;
    logic [NUM_DIGITOS-1:0] vacio;
    logic                   ceros_arriba;

    // Active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank
    function automatic logic [6:0] decodificar(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction: each nibble is adjusted on its own, no carry between nibbles
    always_comb begin
        ajustado = acumulador;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (acumulador[4*i +: 4] > 4'd4) begin
                ajustado[4*i +: 4] = acumulador[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM; bcd_out is only written in FIN so the display never sees partial results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= REPOSO;
            bin        <= '0;
            acumulador <= '0;
            iter       <= '0;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
            bcd_out    <= '0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (cargar) begin
                        bin        <= dato_bin;
                        acumulador <= '0;
                        iter       <= CNT_IT_W'(TAM_REG_BIN);
                        ocupado    <= 1'b1;
                        estado     <= CONVIRTIENDO;
                    end
                end
                CONVIRTIENDO: begin
                    acumulador <= {ajustado[TAM_BCD-2:0], bin[TAM_REG_BIN-1]};
                    bin        <= {bin[TAM_REG_BIN-2:0], 1'b0};
                    iter       <= iter - CNT_IT_W'(1);
                    if (iter == CNT_IT_W'(1)) begin
                        estado <= FIN;
                    end
                end
                FIN: begin
                    bcd_out <= acumulador;
                    listo   <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
            endcase
        end
    end

    // Next scan slot, wrapping after the last digit
    always_comb begin
        if (idx == IDX_W'(NUM_DIGITOS - 1)) begin
            idx_sig = '0;
        end else begin
            idx_sig = idx + IDX_W'(1);
        end
    end

    // Leading-zero mask: digit i>0 is blank when it and every digit above it are zero
    always_comb begin
        ceros_arriba = 1'b1;
        vacio        = '0;
        for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
            ceros_arriba = ceros_arriba & (bcd_out[4*i +: 4] == 4'd0);
            vacio[i]     = ceros_arriba;
        end
    end

    // Nibble and blank flag for the slot about to be shown
    always_comb begin
        digito_sel  = 4'hF;
        apagado_sel = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (idx_sig == IDX_W'(i)) begin
                digito_sel  = bcd_out[4*i +: 4];
                apagado_sel = vacio[i];
            end
        end
    end

    // Scan driver: free-running refresh counter, display registers updated on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_ref   <= '0;
            idx       <= '0;
            anodos    <= '1;
            segmentos <= 7'b1111111;
        end else if (cnt_ref == CNT_REF_W'(DIV_REFRESCO - 1)) begin
            cnt_ref <= '0;
            idx     <= idx_sig;
            if (!habilitado || apagado_sel) begin
                anodos    <= '1;
                segmentos <= 7'b1111111;
            end else begin
                anodos    <= ~(NUM_DIGITOS'(1) << idx_sig);
                segmentos <= decodificar(digito_sel);
            end
        end else begin
            cnt_ref <= cnt_ref + CNT_REF_W'(1);
        end
    end

endmodule

// File: tb/tb_controlador_display_bcd.sv
module tb_controlador_display_bcd;

    localparam int unsigned TAM = 16;
    localparam int unsigned ND  = (TAM + 4) / 4;
    localparam int unsigned DIV = 4;
    localparam int unsigned LAT = TAM + 1;

    logic            clk        = 1'b0;
    logic            reset      = 1'b1;
    logic [TAM-1:0]  dato_bin   = '0;
    logic            cargar     = 1'b0;
    logic            habilitado = 1'b1;
    logic            ocupado;
    logic            listo;
    logic [TAM+3:0]  bcd_out;
    logic [ND-1:0]   anodos;
    logic [6:0]      segmentos;

    controlador_display_bcd #(
        .TAM_REG_BIN (TAM),
        .NUM_DIGITOS (ND),
        .DIV_REFRESCO(DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dato_bin  (dato_bin),
        .cargar    (cargar),
        .habilitado(habilitado),
        .ocupado   (ocupado),
        .listo     (listo),
        .bcd_out   (bcd_out),
        .anodos    (anodos),
        .segmentos (segmentos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int unsigned due;
    } pend_t;

    pend_t       q[$];
    int unsigned cyc     = 0;
    int unsigned busy    = 0;
    int unsigned ref_cnt = 0;
    int unsigned idx     = 0;
    int unsigned shown   = 0;
    logic [ND-1:0] exp_an  = '1;
    logic [6:0]    exp_seg = 7'b1111111;
    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    function automatic logic [TAM+3:0] to_bcd(input int unsigned v);
        logic [TAM+3:0] r;
        int unsigned    t;
        r = '0;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int unsigned pow10(input int unsigned e);
        int unsigned r;
        r = 1;
        repeat (e) r = r * 10;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: request acceptance, result value, and what each scan slot should show
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            busy    = 0;
            ref_cnt = 0;
            idx     = 0;
            shown   = 0;
            exp_an  = '1;
            exp_seg = 7'b1111111;
        end else begin
            cyc++;
            if (ref_cnt == DIV - 1) begin
                ref_cnt = 0;
                idx     = (idx + 1) % ND;
                if (!habilitado || (idx > 0 && shown < pow10(idx))) begin
                    exp_an  = '1;
                    exp_seg = 7'b1111111;
                end else begin
                    exp_an  = ~(ND'(1) << idx);
                    exp_seg = seg_tab[(shown / pow10(idx)) % 10];
                end
            end else begin
                ref_cnt++;
            end
            if (q.size() > 0 && q[0].due == cyc) shown = q[0].val;
            if (busy == 0 && cargar) begin
                q.push_back('{val: 32'(dato_bin), due: cyc + LAT});
                busy = LAT;
            end else if (busy > 0) begin
                busy--;
            end
        end
    end

    // Monitor: pops a pending result whenever listo is seen, checks all outputs every cycle
    always @(negedge clk) begin
        chk("ocupado", 32'(ocupado), 32'(busy != 0));
        if (listo) begin
            if (q.size() == 0) begin
                chk("unexpected_listo", 32'(listo), 32'd0);
            end else begin
                chk("listo_timing", cyc, q[0].due);
                chk("bcd_at_listo", 32'(bcd_out), 32'(to_bcd(q[0].val)));
                void'(q.pop_front());
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_listo", 32'(listo), 32'd1);
            void'(q.pop_front());
        end
        chk("bcd_out", 32'(bcd_out), 32'(to_bcd(shown)));
        chk("anodos", 32'(anodos), 32'(exp_an));
        chk("segmentos", 32'(segmentos), 32'(exp_seg));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convertir(input logic [TAM-1:0] v);
        dato_bin = v;
        cargar   = 1'b1;
        tick();
        cargar   = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ocupado"},   32'(ocupado),   32'd0);
        chk({tag, "_listo"},     32'(listo),     32'd0);
        chk({tag, "_bcd_out"},   32'(bcd_out),   32'd0);
        chk({tag, "_anodos"},    32'(anodos),    32'h1F);
        chk({tag, "_segmentos"}, 32'(segmentos), 32'h7F);
    endtask

    initial begin
        repeat (2) tick();
        chk_reset_values("reset_initial");
        reset = 1'b0;
        tick();

        // Maximum value
        convertir(16'hFFFF);
        repeat (20) tick();

        // Back-to-back with cargar held: second request accepted TAM+2 cycles later
        dato_bin = 16'd9999;
        cargar   = 1'b1;
        tick();
        dato_bin = 16'd0;
        repeat (18) tick();
        cargar = 1'b0;
        repeat (20) tick();

        // Request during a conversion is dropped
        convertir(16'd1234);
        repeat (5) tick();
        convertir(16'd42);
        repeat (15) tick();

        // Reset in the middle of a conversion
        convertir(16'd500);
        repeat (7) tick();
        reset = 1'b1;
        #1;
        chk_reset_values("reset_midconv");
        repeat (2) tick();
        reset = 1'b0;
        repeat (25) tick();

        // Scan of a two-digit value with leading-zero blanking
        convertir(16'd42);
        repeat (45) tick();

        // Zero value, then blank and resume via habilitado
        convertir(16'd0);
        repeat (25) tick();
        habilitado = 1'b0;
        repeat (12) tick();
        habilitado = 1'b1;
        repeat (25) tick();

        // Random traffic
        repeat (25) begin
            dato_bin = TAM'($urandom_range(0, 65535));
            cargar   = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            cargar = 1'b0;
            if ($urandom_range(0, 7) == 0) habilitado = ~habilitado;
            repeat ($urandom_range(0, 25)) tick();
        end
        habilitado = 1'b1;
        repeat (30) tick();

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
